fifo_push_arbiter: RTL and testbench
====================================

# fifo_push_arbiter

Round-robin arbiter that shares the single push port of a `fifo` instance among `nrOfRequesters` producers. Each producer offers words through a valid/ready handshake. A granted producer keeps the port for a whole burst, ending on its `last` marker or after `maxBurst` words, so bursts from different producers never interleave inside the FIFO. The block sits directly in front of the FIFO's `push`/`pushData`/`full` pins.

## Interface
- `nrOfRequesters`, default 4: number of producers, ≥2.
- `bitWidth`, default 32: data word width; matches the FIFO.
- `maxBurst`, default 8: maximum words per grant, ≥1.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low; clears all state immediately while low.
- `reqValid`  in  nrOfRequesters: bit i set means producer i offers a word.
- `reqLast`  in  nrOfRequesters: bit i marks producer i's offered word as the final word of its burst.
- `reqData`  in  nrOfRequesters*bitWidth: producer i's word at bits [i*bitWidth +: bitWidth].
- `fifoFull`  in  1: the FIFO's `full` output.
- `reqReady`  out  nrOfRequesters: one-hot or zero; bit i set means producer i's word is accepted this cycle if valid.
- `fifoPush`  out  1: drives the FIFO's `push`.
- `fifoPushData`  out  bitWidth: drives the FIFO's `pushData`.
- `grantId`  out  max(1,$clog2(nrOfRequesters)): index of the current owner; meaningful only while `busy`=1.
- `busy`  out  1: set while in GRANT.

## Operation
- State machine: IDLE, GRANT.
- Registers:
  - `state`.
  - `grantId`.
  - `lastGrant`, the last producer served.
  - `burstCount`, width $clog2(maxBurst+1).
- Reset values: state=IDLE, grantId=0, lastGrant=nrOfRequesters-1, burstCount=0. All outputs are 0 during and after reset until the first grant.
- IDLE:
  - If any `reqValid` bit is set, select the first set bit searching upward from lastGrant+1, wrapping modulo nrOfRequesters.
  - Load it into grantId, clear burstCount, go to GRANT.
  - Otherwise stay in IDLE.
  - `reqReady`=0 and `fifoPush`=0 in IDLE.
- GRANT with g=grantId:
  - `reqReady[g]` = !fifoFull; all other ready bits are 0.
  - Transfer occurs when reqValid[g] && !fifoFull. Then `fifoPush`=1, `fifoPushData`=reqData slice g, and burstCount increments.
  - Release when a transfer has reqLast[g]=1, or when the transfer is the maxBurst-th word (burstCount==maxBurst-1). On release: lastGrant←g, state←IDLE.
  - If reqValid[g] drops mid-burst, the grant is held with no push until the producer resumes. Bursts are atomic and there is no timeout.
- `fifoPush` is never asserted while `fifoFull`=1, so the FIFO never sees a push it must drop.
- `fifoPushData` = reqData slice grantId whenever busy, and 0 in IDLE.
- `reqLast` on non-granted producers and `reqValid`/`reqLast` in IDLE have no effect except for arbitration.

## Timing
- Arbitration latency is 1 cycle. A request that first appears in IDLE at cycle t gets its grant registered at edge t→t+1, and the first push is possible in cycle t+1.
- The handshake is combinational inside GRANT: ready, push and data follow `fifoFull` and `reqValid` in the same cycle, with no pipeline bubble between words of a burst.
- There is one mandatory IDLE cycle between consecutive bursts, even from the same producer. Peak throughput is therefore maxBurst words per maxBurst+1 cycles.
- Fairness: with all producers continuously requesting, grants rotate 0,1,…,N-1,0,…
- Reset mid-burst:
  - Outputs drop to 0 asynchronously.
  - After reset releases, producer 0 has priority again.
  - The partial burst already in the FIFO is not retracted; this is documented system behaviour.

## Test plan
- **Single burst.** After reset, producer 2 sends words A,B,C with C marked last, fifoFull=0 → grantId=2 from cycle t+1, fifoPush high for 3 cycles carrying A,B,C, then busy=0 for one cycle.
- **Round robin.** Producers 0 and 1 request continuously with 2-word bursts → FIFO receives bursts in order 0,1,0,1. No word of one burst appears between words of another.
- **Max burst cutoff.** maxBurst=8, producer 3 streams 20 words without last → grants of 8, 8 and 4 words, with producer 3 re-granted only after each IDLE cycle.
- **Full stall.** fifoFull rises mid-burst for 3 cycles → reqReady and fifoPush stay 0 for those cycles, grant is held, burstCount is unchanged, and transfer resumes with the next word.
- **Valid gap.** The granted producer drops reqValid for 2 cycles mid-burst while producer 0 requests → grantId is unchanged and producer 0 gets no ready until the burst ends with last.
- **Async reset.** reset goes low mid-cycle during a burst → busy, fifoPush and reqReady go 0 without waiting for a clock edge. After release with producers 0 and 3 requesting, producer 0 is granted first.

Source files
------------

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter
//   Shares one FIFO push port among nrOfRequesters producers. A producer that
//   wins round-robin arbitration owns the port for a whole burst (ending on its
//   reqLast word or after maxBurst words), so bursts never interleave in the FIFO.
//   One IDLE cycle separates consecutive bursts; that cycle is where arbitration
//   happens.
// Ports
//   clock, reset         : rising-edge clock, async active-low reset
//   reqValid/reqLast     : per-producer offer and end-of-burst marker
//   reqData              : producer i's word at [i*bitWidth +: bitWidth]
//   fifoFull             : FIFO full flag
//   reqReady             : one-hot (or zero) accept strobe back to producers
//   fifoPush/fifoPushData: FIFO push pins
//   grantId, busy        : current owner, valid while busy

// Per-producer slice of the handshake: owner decode, ready, push and data gating.
module fpa_lane #(
  parameter int bitWidth = 32,
  parameter int GW       = 2,
  parameter int ID       = 0
) (
  input  logic                i_busy,
  input  logic [GW-1:0]       i_grantId,
  input  logic                i_fifoFull,
  input  logic                i_valid,
  input  logic [bitWidth-1:0] i_data,
  output logic                o_ready,
  output logic                o_push,
  output logic [bitWidth-1:0] o_data
);
  logic w_owner;

  assign w_owner = i_busy && (i_grantId == GW'(ID));
  assign o_ready = w_owner && !i_fifoFull;
  assign o_push  = o_ready && i_valid;
  // Non-owners contribute zero so the top can OR all lanes together.
  assign o_data  = w_owner ? i_data : '0;
endmodule

module fifo_push_arbiter #(
  parameter int nrOfRequesters = 4,
  parameter int bitWidth       = 32,
  parameter int maxBurst       = 8,
  localparam int GW  = (nrOfRequesters > 1) ? $clog2(nrOfRequesters) : 1,
  localparam int BCW = $clog2(maxBurst + 1)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [nrOfRequesters-1:0]          reqValid,
  input  logic [nrOfRequesters-1:0]          reqLast,
  input  logic [nrOfRequesters*bitWidth-1:0] reqData,
  input  logic                               fifoFull,
  output logic [nrOfRequesters-1:0]          reqReady,
  output logic                               fifoPush,
  output logic [bitWidth-1:0]                fifoPushData,
  output logic [GW-1:0]                      grantId,
  output logic                               busy
);
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          r_state, w_stateNxt;
  logic [GW-1:0]   r_grantId, w_grantNxt;
  logic [GW-1:0]   r_lastGrant, w_lastNxt;
  logic [BCW-1:0]  r_burstCount, w_countNxt;

  logic                                     w_busy;
  logic                                     w_xfer;
  logic                                     w_lastSel;
  logic                                     w_found;
  logic [GW-1:0]                            w_pick;
  logic [31:0]                              w_idx;
  logic [nrOfRequesters-1:0]                w_ready;
  logic [nrOfRequesters-1:0]                w_push;
  logic [nrOfRequesters-1:0][bitWidth-1:0]  w_laneData;
  logic [bitWidth-1:0]                      w_pushData;

  assign w_busy = (r_state == GRANT);

  genvar gi;
  generate
    for (gi = 0; gi < nrOfRequesters; gi++) begin : g_lane
      fpa_lane #(.bitWidth(bitWidth), .GW(GW), .ID(gi)) u_lane (
        .i_busy    (w_busy),
        .i_grantId (r_grantId),
        .i_fifoFull(fifoFull),
        .i_valid   (reqValid[gi]),
        .i_data    (reqData[gi*bitWidth +: bitWidth]),
        .o_ready   (w_ready[gi]),
        .o_push    (w_push[gi]),
        .o_data    (w_laneData[gi])
      );
    end
  endgenerate

  always_comb begin
    w_pushData = '0;
    for (int i = 0; i < nrOfRequesters; i++) w_pushData = w_pushData | w_laneData[i];
  end

  assign w_xfer    = |w_push;
  assign w_lastSel = reqLast[r_grantId];

  // Round-robin pick: first valid producer searching upward from lastGrant+1.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 1; k <= nrOfRequesters; k++) begin
      w_idx = (32'(r_lastGrant) + 32'(unsigned'(k))) % 32'(unsigned'(nrOfRequesters));
      if (!w_found && reqValid[w_idx[GW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[GW-1:0];
      end
    end
  end

  always_comb begin
    w_stateNxt = r_state;
    w_grantNxt = r_grantId;
    w_lastNxt  = r_lastGrant;
    w_countNxt = r_burstCount;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_stateNxt = GRANT;
          w_grantNxt = w_pick;
          w_countNxt = '0;
        end
      end
      GRANT: begin
        // A held grant with no transfer (full or valid gap) leaves the count alone.
        if (w_xfer) begin
          w_countNxt = r_burstCount + BCW'(1);
          if (w_lastSel || (r_burstCount == BCW'(maxBurst - 1))) begin
            w_stateNxt = IDLE;
            w_lastNxt  = r_grantId;
          end
        end
      end
      default: w_stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_grantId    <= '0;
      r_lastGrant  <= GW'(nrOfRequesters - 1);
      r_burstCount <= '0;
    end else begin
      r_state      <= w_stateNxt;
      r_grantId    <= w_grantNxt;
      r_lastGrant  <= w_lastNxt;
      r_burstCount <= w_countNxt;
    end
  end

  // All outputs derive from registered state, so they clear as soon as reset asserts.
  assign reqReady     = w_ready;
  assign fifoPush     = w_xfer;
  assign fifoPushData = w_pushData;
  assign grantId      = r_grantId;
  assign busy         = w_busy;
endmodule

// File: tb/tb_fifo_push_arbiter.sv
module tb_fifo_push_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int MB = 8;
  localparam int GW = 2;

  typedef struct {
    logic [GW-1:0] id;
    logic [W-1:0]  data;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset;
  logic [N-1:0]     reqValid, reqLast, reqReady;
  logic [N*W-1:0]   reqData;
  logic             fifoFull, fifoPush, busy;
  logic [W-1:0]     fifoPushData;
  logic [GW-1:0]    grantId;

  fifo_push_arbiter #(.nrOfRequesters(N), .bitWidth(W), .maxBurst(MB)) dut (
    .clock(clock), .reset(reset), .reqValid(reqValid), .reqLast(reqLast),
    .reqData(reqData), .fifoFull(fifoFull), .reqReady(reqReady),
    .fifoPush(fifoPush), .fifoPushData(fifoPushData), .grantId(grantId), .busy(busy)
  );

  always #5 clock = ~clock;

  int           n_pass = 0;
  int           n_total = 0;
  int           cyc = 0;
  logic [W:0]   pq [N][$];     // per-producer word queue, bit W = last
  logic [N-1:0] hold = '0;     // forces a producer's valid low
  logic [N-1:0] hs = '0;       // handshake seen at last negedge
  exp_t         expq[$];
  int           pcyc[$];       // cycle numbers of observed pushes

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic present();
    for (int i = 0; i < N; i++) begin
      if (!hold[i] && pq[i].size() > 0) begin
        reqValid[i]          = 1'b1;
        reqLast[i]           = pq[i][0][W];
        reqData[i*W +: W]    = pq[i][0][W-1:0];
      end else begin
        reqValid[i]          = 1'b0;
        reqLast[i]           = 1'b0;
        reqData[i*W +: W]    = '0;
      end
    end
  endtask

  task automatic enq(input int p, input logic [W-1:0] d, input logic last);
    exp_t e;
    pq[p].push_back({last, d});
    e.id = GW'(p);
    e.data = d;
    expq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((expq.size() != 0 || busy) && k < 300) begin
      @(negedge clock);
      k++;
    end
    check(name, 64'(expq.size()), 64'd0);
    tick();
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Producer driver: retire accepted words, then present the next ones.
  initial forever begin
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++)
      if (hs[i] && pq[i].size() > 0) void'(pq[i].pop_front());
    present();
  end

  // Monitor: samples handshakes and checks every push against the scoreboard.
  initial forever begin
    exp_t e;
    @(negedge clock);
    hs = reqReady & reqValid;
    if (reset && fifoPush) begin
      pcyc.push_back(cyc);
      check("push_while_full", 64'(fifoFull), 64'd0);
      if (expq.size() == 0) begin
        check("unexpected_push", 64'(fifoPushData), 64'hDEAD);
      end else begin
        e = expq.pop_front();
        check("push_data", 64'(fifoPushData), 64'(e.data));
        check("push_owner", 64'(grantId), 64'(e.id));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; reqValid = '0; reqLast = '0; reqData = '0; fifoFull = 1'b0;
    @(negedge clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_push", 64'(fifoPush), 64'd0);
    check("rst_ready", 64'(reqReady), 64'd0);
    check("rst_grant", 64'(grantId), 64'd0);
    check("rst_data", 64'(fifoPushData), 64'd0);
    tick();
    reset = 1'b1;
    tick();

    // Single burst from producer 2.
    enq(2, 32'hA, 1'b0); enq(2, 32'hB, 1'b0); enq(2, 32'hC, 1'b1);
    present();
    @(negedge clock);
    check("s1_idle_busy", 64'(busy), 64'd0);
    check("s1_idle_ready", 64'(reqReady), 64'd0);
    tick(); @(negedge clock);
    check("s1_busy", 64'(busy), 64'd1);
    check("s1_grant", 64'(grantId), 64'd2);
    check("s1_push0", 64'(fifoPush), 64'd1);
    tick(); @(negedge clock);
    check("s1_push1", 64'(fifoPush), 64'd1);
    tick(); @(negedge clock);
    check("s1_push2", 64'(fifoPush), 64'd1);
    tick(); @(negedge clock);
    check("s1_release_busy", 64'(busy), 64'd0);
    check("s1_release_push", 64'(fifoPush), 64'd0);
    drain("s1_drain");

    // Round robin: 2-word bursts from producers 0 and 1 alternate.
    for (int k = 0; k < 2; k++) begin
      enq(0, 32'h100 + 32'(2*k),     1'b0);
      enq(0, 32'h100 + 32'(2*k + 1), 1'b1);
      enq(1, 32'h200 + 32'(2*k),     1'b0);
      enq(1, 32'h200 + 32'(2*k + 1), 1'b1);
    end
    // Scoreboard order must be 0,1,0,1: rebuild it burst-wise.
    expq.delete();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++)
        for (int j = 0; j < 2; j++) begin
          exp_t e;
          e.id = GW'(p);
          e.data = 32'h100 * 32'(p + 1) + 32'(2*k + j);
          expq.push_back(e);
        end
    present();
    drain("s2_drain");

    // Max-burst cutoff: 20 words from producer 3 -> 8, 8, 4.
    pcyc.delete();
    for (int k = 0; k < 20; k++) enq(3, 32'h3000 + 32'(k), k == 19);
    present();
    drain("s3_drain");
    check("s3_gap_after_8", 64'(pcyc[8] - pcyc[7]), 64'd2);
    check("s3_gap_after_16", 64'(pcyc[16] - pcyc[15]), 64'd2);
    check("s3_span", 64'(pcyc[19] - pcyc[0]), 64'd21);

    // Full stall for 3 cycles after two words; stalled cycles must not count.
    pcyc.delete();
    for (int k = 0; k < 9; k++) enq(1, 32'h4000 + 32'(k), k == 8);
    present();
    tick(); tick(); tick();
    fifoFull = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("s4_ready", 64'(reqReady), 64'd0);
      check("s4_push", 64'(fifoPush), 64'd0);
      check("s4_busy", 64'(busy), 64'd1);
      check("s4_grant", 64'(grantId), 64'd1);
      tick();
    end
    fifoFull = 1'b0;
    drain("s4_drain");
    check("s4_stall_gap", 64'(pcyc[2] - pcyc[1]), 64'd4);
    check("s4_cutoff_gap", 64'(pcyc[8] - pcyc[7]), 64'd2);

    // Valid gap: producer 2 pauses, producer 0 must wait for the burst's end.
    for (int k = 0; k < 4; k++) enq(2, 32'h5000 + 32'(k), k == 3);
    present();
    tick(); tick(); tick();
    hold[2] = 1'b1;
    enq(0, 32'h6000, 1'b0); enq(0, 32'h6001, 1'b1);
    present();
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      check("s5_grant", 64'(grantId), 64'd2);
      check("s5_busy", 64'(busy), 64'd1);
      check("s5_p0_ready", 64'(reqReady[0]), 64'd0);
      check("s5_push", 64'(fifoPush), 64'd0);
      tick();
    end
    hold[2] = 1'b0;
    present();
    drain("s5_drain");

    // Async reset mid-burst; afterwards producer 0 beats producer 3.
    for (int k = 0; k < 6; k++) pq[1].push_back({k == 5, 32'h7000 + 32'(k)});
    begin
      exp_t e;
      e.id = 2'd1;
      e.data = 32'h7000;
      expq.push_back(e);
    end
    present();
    tick(); tick();
    #1 reset = 1'b0;
    #1;
    check("s6_async_busy", 64'(busy), 64'd0);
    check("s6_async_push", 64'(fifoPush), 64'd0);
    check("s6_async_ready", 64'(reqReady), 64'd0);
    check("s6_async_grant", 64'(grantId), 64'd0);
    pq[1].delete();
    enq(0, 32'h8000, 1'b1);
    enq(3, 32'h8003, 1'b1);
    present();
    tick(); tick();
    reset = 1'b1;
    drain("s6_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
